// File: rtl/ripple_cnt_pkg.sv
// Shared constants and helpers for the ripple counter block.
// Used by the counter top level and by its testbench.
package ripple_cnt_pkg;

   localparam int unsigned CNT_MAX_W = 16;

   // Largest count a chain of the given width can hold (2^width - 1).
   function automatic logic [CNT_MAX_W-1:0] cnt_max(input int unsigned width);
      logic [CNT_MAX_W:0] full;
      full = (CNT_MAX_W+1)'(1) << width;
      return CNT_MAX_W'(full - 1'b1);
   endfunction

endpackage : ripple_cnt_pkg

// File: rtl/ripple_tff.sv
// Single toggle flip-flop stage of the ripple counter.
// q inverts on every rising clk edge; rst_n clears it asynchronously.
module ripple_tff (
   input  logic clk,
   input  logic rst_n,
   output logic q
);

   // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else        q <= ~q;
   end

endmodule : ripple_tff

// File: rtl/ripple_carry_counter.sv
// Asynchronous (ripple) binary up-counter built from a chain of toggle flops.
// Define RIPPLE_CNT_SYNC_OUT_EN to take E from a glitch-free register clocked by A.
module ripple_carry_counter
   import ripple_cnt_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             A,
   input  logic             B,
   output logic [WIDTH-1:0] E
);

   if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
      $error("ripple_carry_counter: WIDTH out of range 1..16");
   end

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] stage_clk;

   // Each stage is clocked by the inverted previous stage, so it toggles on that stage's 1->0 carry.
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      if (i == 0) begin : g_first
         assign stage_clk[i] = A;
      end else begin : g_next
         assign stage_clk[i] = ~q[i-1];
      end

      ripple_tff u_tff (
         .clk   (stage_clk[i]),
         .rst_n (B),
         .q     (q[i])
      );
   end

`ifdef RIPPLE_CNT_SYNC_OUT_EN
   logic [WIDTH-1:0] e_reg;

   // Captures the value settled before this edge, so E trails the chain by one A cycle.
   always_ff @(posedge A or negedge B) begin
      if (!B) e_reg <= '0;
      else    e_reg <= q;
   end

   assign E = e_reg;
`else
   assign E = q;
`endif

endmodule : ripple_carry_counter

// File: tb/tb_ripple_carry_counter.sv
// Directed testbench for ripple_carry_counter (WIDTH=4 and WIDTH=1 instances).
// Expected values follow the registered-output lag when RIPPLE_CNT_SYNC_OUT_EN is defined.
module tb_ripple_carry_counter;
   import ripple_cnt_pkg::*;

`ifdef RIPPLE_CNT_SYNC_OUT_EN
   localparam bit SYNC = 1'b1;
`else
   localparam bit SYNC = 1'b0;
`endif

   logic       A  = 1'b0;
   logic       A1 = 1'b0;
   logic       B  = 1'b1;
   logic [3:0] E;
   logic [0:0] E1;

   int n_pass  = 0;
   int n_total = 0;
   int pulses  = 0;
   int pulses1 = 0;
   bit watch   = 1'b0;
   int glitches = 0;

   ripple_carry_counter #(.WIDTH(4)) dut (
      .A (A),
      .B (B),
      .E (E)
   );

   ripple_carry_counter #(.WIDTH(1)) dut1 (
      .A (A1),
      .B (B),
      .E (E1)
   );

   // Registered output may only move between 7 and 8 during the settling window.
   always @(E) begin
      if (watch && SYNC && E !== 4'd7 && E !== 4'd8) glitches++;
   end

   // Expected E after n rising edges of A since reset release.
   function automatic logic [3:0] exp4(input int n);
      if (SYNC) return (n == 0) ? 4'd0 : 4'((n - 1) % 16);
      return 4'(n % 16);
   endfunction

   function automatic logic [0:0] exp1(input int n);
      if (SYNC) return (n == 0) ? 1'b0 : 1'((n - 1) % 2);
      return 1'(n % 2);
   endfunction

   task automatic pulse(input int k);
      for (int i = 0; i < k; i++) begin
         A = 1'b1; #5;
         A = 1'b0; #5;
      end
      pulses += k;
   endtask

   task automatic pulse1;
      A1 = 1'b1; #5;
      A1 = 1'b0; #5;
      pulses1++;
   endtask

   task automatic do_reset;
      B = 1'b0; #1;
      B = 1'b1; #5;
      pulses  = 0;
      pulses1 = 0;
   endtask

   task automatic test_reset;
      #1 B = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1 A = ~A;
         n_total++;
         if (E !== 4'd0) $display("FAIL reset_hold[%0d]: E=%0d expected 0", i, E);
         else n_pass++;
      end
      A = 1'b0; #2;
      B = 1'b1; #5;
      pulses = 0;
      pulse(3);
      n_total++;
      if (E !== exp4(3)) $display("FAIL pre_reset_count: E=%0d expected %0d", E, exp4(3));
      else n_pass++;
      B = 1'b0; #1;
      n_total++;
      if (E !== 4'd0) $display("FAIL reset_immediate: E=%0d expected 0", E);
      else n_pass++;
   endtask

   task automatic test_count;
      B = 1'b1; #5;
      pulses = 0;
      pulse(5);
      n_total++;
      if (E !== exp4(5)) $display("FAIL count_5: E=%0d expected %0d", E, exp4(5));
      else n_pass++;
      pulse(9);
      n_total++;
      if (E !== exp4(14)) $display("FAIL count_14: E=%0d expected %0d", E, exp4(14));
      else n_pass++;
   endtask

   task automatic test_wrap;
      pulse(1);
      n_total++;
      if (E !== (SYNC ? 4'd14 : cnt_max(4)))
         $display("FAIL wrap_max: E=%0d expected %0d", E, SYNC ? 4'd14 : cnt_max(4));
      else n_pass++;
      for (int k = 16; k <= 18; k++) begin
         pulse(1);
         n_total++;
         if (E !== exp4(k)) $display("FAIL wrap_after[%0d]: E=%0d expected %0d", k, E, exp4(k));
         else n_pass++;
      end
   endtask

   task automatic test_mid_reset;
      do_reset();
      pulse(6);
      n_total++;
      if (E !== exp4(6)) $display("FAIL mid_pre: E=%0d expected %0d", E, exp4(6));
      else n_pass++;
      B = 1'b0; #1;
      n_total++;
      if (E !== 4'd0) $display("FAIL mid_clear: E=%0d expected 0", E);
      else n_pass++;
      B = 1'b1; #5;
      pulses = 0;
      n_total++;
      if (E !== 4'd0) $display("FAIL mid_release: E=%0d expected 0", E);
      else n_pass++;
      pulse(1);
      n_total++;
      if (E !== exp4(1)) $display("FAIL mid_first: E=%0d expected %0d", E, exp4(1));
      else n_pass++;
   endtask

   task automatic test_settling;
      int pre;
      do_reset();
      pre = SYNC ? 8 : 7;
      pulse(pre);
      n_total++;
      if (E !== 4'd7) $display("FAIL settle_pre: E=%0d expected 7", E);
      else n_pass++;
      glitches = 0;
      watch = 1'b1;
      A = 1'b1; #1;
      n_total++;
      if (E !== 4'd8) $display("FAIL settle_8: E=%0d expected 8", E);
      else n_pass++;
      #4 A = 1'b0; #5;
      pulses++;
      watch = 1'b0;
      n_total++;
      if (glitches !== 0) $display("FAIL settle_glitch: count=%0d expected 0", glitches);
      else n_pass++;
   endtask

   task automatic test_width1;
      do_reset();
      n_total++;
      if (E1 !== 1'b0) $display("FAIL w1_reset: E=%0d expected 0", E1);
      else n_pass++;
      for (int k = 1; k <= 3; k++) begin
         pulse1();
         n_total++;
         if (E1 !== exp1(k)) $display("FAIL w1_step[%0d]: E=%0d expected %0d", k, E1, exp1(k));
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_wrap();
      test_mid_reset();
      test_settling();
      test_width1();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_ripple_carry_counter
